// File: rtl/instruction_decode.sv
// RV32I decode stage: splits the fetched instruction into fields, builds the immediate,
// and registers everything for execute with stall hold and flush kill.
module instruction_decode #(
  parameter int unsigned I_WIDTH        = 32,
  parameter int unsigned PC_WIDTH       = 32,
  parameter int unsigned REG_ADDR_WIDTH = 5
) (
  input  logic                      d_clk,
  input  logic                      d_rst,
  input  logic [I_WIDTH-1:0]        i_instr,
  input  logic [PC_WIDTH-1:0]       i_pc,
  input  logic                      i_ce,
  input  logic                      i_stall,
  input  logic                      i_flush,
  output logic                      o_stall,
  output logic                      o_ce,
  output logic [PC_WIDTH-1:0]       o_pc,
  output logic [6:0]                o_opcode,
  output logic [2:0]                o_funct3,
  output logic                      o_funct7_b5,
  output logic [REG_ADDR_WIDTH-1:0] o_rs1_addr,
  output logic [REG_ADDR_WIDTH-1:0] o_rs2_addr,
  output logic [REG_ADDR_WIDTH-1:0] o_rd_addr,
  output logic [31:0]               o_imm,
  output logic                      o_rd_we,
  output logic                      o_illegal
);

  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpOpImm  = 7'b0010011;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpOp     = 7'b0110011;
  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpSystem = 7'b1110011;
  localparam logic [6:0] OpFence  = 7'b0001111;

  logic [6:0]                opcode_d;
  logic [REG_ADDR_WIDTH-1:0] rd_d;
  logic [31:0]               imm_d;
  logic                      rd_we_d;
  logic                      illegal_d;

  logic                      ce_q;
  logic [PC_WIDTH-1:0]       pc_q;
  logic [6:0]                opcode_q;
  logic [2:0]                funct3_q;
  logic                      funct7_b5_q;
  logic [REG_ADDR_WIDTH-1:0] rs1_q;
  logic [REG_ADDR_WIDTH-1:0] rs2_q;
  logic [REG_ADDR_WIDTH-1:0] rd_q;
  logic [31:0]               imm_q;
  logic                      rd_we_q;
  logic                      illegal_q;

  assign opcode_d = i_instr[6:0];
  assign rd_d     = i_instr[7 +: REG_ADDR_WIDTH];

  always_comb begin
    imm_d     = 32'd0;
    rd_we_d   = 1'b0;
    illegal_d = 1'b0;
    unique case (opcode_d)
      OpLoad, OpOpImm, OpJalr: begin
        imm_d   = {{20{i_instr[31]}}, i_instr[31:20]};
        rd_we_d = 1'b1;
      end
      OpSystem, OpFence: imm_d = {{20{i_instr[31]}}, i_instr[31:20]};
      OpStore:  imm_d = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
      OpBranch: imm_d = {{20{i_instr[31]}}, i_instr[7], i_instr[30:25], i_instr[11:8], 1'b0};
      OpLui, OpAuipc: begin
        imm_d   = {i_instr[31:12], 12'd0};
        rd_we_d = 1'b1;
      end
      OpJal: begin
        imm_d   = {{12{i_instr[31]}}, i_instr[19:12], i_instr[20], i_instr[30:21], 1'b0};
        rd_we_d = 1'b1;
      end
      OpOp:     rd_we_d = 1'b1;
      default:  illegal_d = 1'b1;
    endcase
    // Writes to x0 are architecturally discarded, so suppress them here.
    if (rd_d == '0) rd_we_d = 1'b0;
  end

  always_ff @(posedge d_clk or posedge d_rst) begin
    if (d_rst) begin
      ce_q        <= 1'b0;
      pc_q        <= '0;
      opcode_q    <= '0;
      funct3_q    <= '0;
      funct7_b5_q <= 1'b0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      rd_q        <= '0;
      imm_q       <= '0;
      rd_we_q     <= 1'b0;
      illegal_q   <= 1'b0;
    end else if (i_flush) begin
      ce_q      <= 1'b0;
      rd_we_q   <= 1'b0;
      illegal_q <= 1'b0;
    end else if (i_stall) begin
      // Hold everything, including the valid, until downstream drains.
      ce_q <= ce_q;
    end else if (i_ce) begin
      ce_q        <= 1'b1;
      pc_q        <= i_pc;
      opcode_q    <= opcode_d;
      funct3_q    <= i_instr[14:12];
      funct7_b5_q <= i_instr[30];
      rs1_q       <= i_instr[15 +: REG_ADDR_WIDTH];
      rs2_q       <= i_instr[20 +: REG_ADDR_WIDTH];
      rd_q        <= rd_d;
      imm_q       <= imm_d;
      rd_we_q     <= rd_we_d;
      illegal_q   <= illegal_d;
    end else begin
      ce_q      <= 1'b0;
      rd_we_q   <= 1'b0;
      illegal_q <= 1'b0;
    end
  end

  // Released during flush so fetch can take the redirect.
  assign o_stall     = i_stall & ~i_flush;
  assign o_ce        = ce_q;
  assign o_pc        = pc_q;
  assign o_opcode    = opcode_q;
  assign o_funct3    = funct3_q;
  assign o_funct7_b5 = funct7_b5_q;
  assign o_rs1_addr  = rs1_q;
  assign o_rs2_addr  = rs2_q;
  assign o_rd_addr   = rd_q;
  assign o_imm       = imm_q;
  assign o_rd_we     = rd_we_q;
  assign o_illegal   = illegal_q;

endmodule

// File: tb/tb_instruction_decode.sv
// Directed vector bench for instruction_decode: decode table plus reset, stall, flush,
// idle and illegal sequences.
module tb_instruction_decode;

  logic        d_clk;
  logic        d_rst;
  logic [31:0] i_instr;
  logic [31:0] i_pc;
  logic        i_ce;
  logic        i_stall;
  logic        i_flush;
  logic        o_stall;
  logic        o_ce;
  logic [31:0] o_pc;
  logic [6:0]  o_opcode;
  logic [2:0]  o_funct3;
  logic        o_funct7_b5;
  logic [4:0]  o_rs1_addr;
  logic [4:0]  o_rs2_addr;
  logic [4:0]  o_rd_addr;
  logic [31:0] o_imm;
  logic        o_rd_we;
  logic        o_illegal;

  int checks = 0;
  int errors = 0;

  instruction_decode #(
    .I_WIDTH       (32),
    .PC_WIDTH      (32),
    .REG_ADDR_WIDTH(5)
  ) dut (
    .d_clk      (d_clk),
    .d_rst      (d_rst),
    .i_instr    (i_instr),
    .i_pc       (i_pc),
    .i_ce       (i_ce),
    .i_stall    (i_stall),
    .i_flush    (i_flush),
    .o_stall    (o_stall),
    .o_ce       (o_ce),
    .o_pc       (o_pc),
    .o_opcode   (o_opcode),
    .o_funct3   (o_funct3),
    .o_funct7_b5(o_funct7_b5),
    .o_rs1_addr (o_rs1_addr),
    .o_rs2_addr (o_rs2_addr),
    .o_rd_addr  (o_rd_addr),
    .o_imm      (o_imm),
    .o_rd_we    (o_rd_we),
    .o_illegal  (o_illegal)
  );

  initial d_clk = 1'b0;
  always #5 d_clk = ~d_clk;

  typedef struct {
    logic [31:0] instr;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        f7;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic        we;
    logic        ill;
  } vec_t;

  vec_t vecs[15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_fields(input string tag, input vec_t v);
    check({tag, " opcode"}, {25'd0, o_opcode}, {25'd0, v.op});
    check({tag, " funct3"}, {29'd0, o_funct3}, {29'd0, v.f3});
    check({tag, " funct7_b5"}, {31'd0, o_funct7_b5}, {31'd0, v.f7});
    check({tag, " rs1"}, {27'd0, o_rs1_addr}, {27'd0, v.rs1});
    check({tag, " rs2"}, {27'd0, o_rs2_addr}, {27'd0, v.rs2});
    check({tag, " rd"}, {27'd0, o_rd_addr}, {27'd0, v.rd});
    check({tag, " imm"}, o_imm, v.imm);
    check({tag, " rd_we"}, {31'd0, o_rd_we}, {31'd0, v.we});
    check({tag, " illegal"}, {31'd0, o_illegal}, {31'd0, v.ill});
  endtask

  task automatic tick();
    @(posedge d_clk);
    #1;
  endtask

  task automatic apply(input vec_t v, input logic [31:0] pc);
    i_instr = v.instr;
    i_pc    = pc;
    i_ce    = 1'b1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " ce"}, {31'd0, o_ce}, 32'd0);
    check({tag, " pc"}, o_pc, 32'd0);
    check({tag, " fields"}, {o_opcode, o_funct3, o_funct7_b5, o_rs1_addr, o_rs2_addr,
                             o_rd_addr, o_rd_we, o_illegal}, 32'd0);
    check({tag, " imm"}, o_imm, 32'd0);
  endtask

  initial begin
    //            instr         op     f3    f7    rs1    rs2    rd     imm            we    ill
    vecs[0]  = '{32'h00500093, 7'h13, 3'd0, 1'b0, 5'd0,  5'd5,  5'd1,  32'h00000005, 1'b1, 1'b0};
    vecs[1]  = '{32'h0020A423, 7'h23, 3'd2, 1'b0, 5'd1,  5'd2,  5'd8,  32'h00000008, 1'b0, 1'b0};
    vecs[2]  = '{32'hFE000EE3, 7'h63, 3'd0, 1'b1, 5'd0,  5'd0,  5'd29, 32'hFFFFFFFC, 1'b0, 1'b0};
    vecs[3]  = '{32'h123452B7, 7'h37, 3'd5, 1'b0, 5'd8,  5'd3,  5'd5,  32'h12345000, 1'b1, 1'b0};
    vecs[4]  = '{32'h80000017, 7'h17, 3'd0, 1'b0, 5'd0,  5'd0,  5'd0,  32'h80000000, 1'b0, 1'b0};
    vecs[5]  = '{32'hFF9FF0EF, 7'h6F, 3'd7, 1'b1, 5'd31, 5'd25, 5'd1,  32'hFFFFFFF8, 1'b1, 1'b0};
    vecs[6]  = '{32'h010101E7, 7'h67, 3'd0, 1'b0, 5'd2,  5'd16, 5'd3,  32'h00000010, 1'b1, 1'b0};
    vecs[7]  = '{32'hFFF2A203, 7'h03, 3'd2, 1'b1, 5'd5,  5'd31, 5'd4,  32'hFFFFFFFF, 1'b1, 1'b0};
    vecs[8]  = '{32'h40838333, 7'h33, 3'd0, 1'b1, 5'd7,  5'd8,  5'd6,  32'h00000000, 1'b1, 1'b0};
    vecs[9]  = '{32'h00000073, 7'h73, 3'd0, 1'b0, 5'd0,  5'd0,  5'd0,  32'h00000000, 1'b0, 1'b0};
    vecs[10] = '{32'h0FF0000F, 7'h0F, 3'd0, 1'b0, 5'd0,  5'd31, 5'd0,  32'h000000FF, 1'b0, 1'b0};
    vecs[11] = '{32'h00000013, 7'h13, 3'd0, 1'b0, 5'd0,  5'd0,  5'd0,  32'h00000000, 1'b0, 1'b0};
    vecs[12] = '{32'hFFFFFFFF, 7'h7F, 3'd7, 1'b1, 5'd31, 5'd31, 5'd31, 32'h00000000, 1'b0, 1'b1};
    vecs[13] = '{32'h00000000, 7'h00, 3'd0, 1'b0, 5'd0,  5'd0,  5'd0,  32'h00000000, 1'b0, 1'b1};
    vecs[14] = '{32'h0000005B, 7'h5B, 3'd0, 1'b0, 5'd0,  5'd0,  5'd0,  32'h00000000, 1'b0, 1'b1};

    // Reset held with a valid instruction presented.
    d_rst   = 1'b1;
    i_stall = 1'b0;
    i_flush = 1'b0;
    apply(vecs[0], 32'h4);
    tick();
    check_all_zero("reset cycle1");
    tick();
    check_all_zero("reset cycle2");
    d_rst = 1'b0;

    // Decode table, one instruction per cycle.
    for (int i = 0; i < 15; i++) begin
      apply(vecs[i], 32'h4 + 32'(i) * 32'h4);
      tick();
      check($sformatf("vec%0d ce", i), {31'd0, o_ce}, 32'd1);
      check($sformatf("vec%0d pc", i), o_pc, 32'h4 + 32'(i) * 32'h4);
      check_fields($sformatf("vec%0d", i), vecs[i]);
    end

    // Stall holds ADDI while SW waits at the input.
    apply(vecs[0], 32'h100);
    tick();
    i_stall = 1'b1;
    apply(vecs[1], 32'h104);
    #1;
    check("stall o_stall", {31'd0, o_stall}, 32'd1);
    for (int c = 0; c < 3; c++) begin
      tick();
      check($sformatf("stall%0d ce", c), {31'd0, o_ce}, 32'd1);
      check($sformatf("stall%0d pc", c), o_pc, 32'h100);
      check_fields($sformatf("stall%0d", c), vecs[0]);
    end
    i_stall = 1'b0;
    tick();
    check("post-stall pc", o_pc, 32'h104);
    check_fields("post-stall", vecs[1]);

    // Flush beats simultaneous stall and valid; kills a rd-writing instruction.
    apply(vecs[3], 32'h108);
    tick();
    check("pre-flush rd_we", {31'd0, o_rd_we}, 32'd1);
    i_flush = 1'b1;
    i_stall = 1'b1;
    apply(vecs[5], 32'h10C);
    #1;
    check("flush o_stall", {31'd0, o_stall}, 32'd0);
    tick();
    check("flush ce", {31'd0, o_ce}, 32'd0);
    check("flush rd_we", {31'd0, o_rd_we}, 32'd0);
    check("flush imm hold", o_imm, 32'h12345000);
    check("flush pc hold", o_pc, 32'h108);
    i_flush = 1'b0;
    i_stall = 1'b0;

    // Illegal then idle: valid and illegal drop, fields hold.
    apply(vecs[12], 32'h200);
    tick();
    check("illegal ce", {31'd0, o_ce}, 32'd1);
    check("illegal flag", {31'd0, o_illegal}, 32'd1);
    i_ce = 1'b0;
    tick();
    check("idle ce", {31'd0, o_ce}, 32'd0);
    check("idle illegal", {31'd0, o_illegal}, 32'd0);
    check("idle opcode hold", {25'd0, o_opcode}, 32'h7F);

    // Flush clears a captured illegal.
    apply(vecs[13], 32'h204);
    tick();
    check("illegal2 flag", {31'd0, o_illegal}, 32'd1);
    i_flush = 1'b1;
    tick();
    check("flush illegal", {31'd0, o_illegal}, 32'd0);
    i_flush = 1'b0;

    // Asynchronous reset mid-cycle clears outputs before the next edge.
    apply(vecs[5], 32'h300);
    tick();
    check("pre-reset ce", {31'd0, o_ce}, 32'd1);
    d_rst = 1'b1;
    #1;
    check_all_zero("async reset");
    d_rst = 1'b0;
    tick();
    check("after reset ce", {31'd0, o_ce}, 32'd1);
    check_fields("after reset", vecs[5]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
